unit_wb_collector: RTL and testbench
====================================

Name: unit_wb_collector

Overview:
- Consumer end of the unit writeback interface.
- Each execution unit (ALU, branch, mul/div, LSU) pulses done with rd/id/pc.
- The block captures every pulse in a small per-unit FIFO and round-robin arbitrates the entries onto a single register-file / DExIE dataflow writeback port with valid/ready handshake.
- It also returns per-unit ready so the issue stage stops issuing to a unit whose buffer is full.

Parameters:
- NUM_UNITS, 4, number of writeback sources; index 0 is the ALU.
- FIFO_DEPTH, 2, entries per unit FIFO; power of two, ≥2.
- ID_W, 3, instruction id width.
- XLEN comes from taiga_config and is not a parameter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- unit_done  in  NUM_UNITS  per-unit writeback pulse (wb.done)
- unit_rd  in  NUM_UNITS×XLEN  per-unit result
- unit_id  in  NUM_UNITS×ID_W  per-unit instruction id
- unit_pc  in  NUM_UNITS×32  per-unit PC (DExIE dataflow)
- unit_ready  out  NUM_UNITS  unit FIFO can accept a push this cycle; issue gates new_request on this
- wb_valid  out  1  writeback entry presented
- wb_ready  in  1  register file / trace sink accepts
- wb_rd  out  XLEN  selected result
- wb_id  out  ID_W  selected id
- wb_pc  out  32  selected PC
- wb_unit  out  clog2(NUM_UNITS)  source index of the presented entry
- overflow_err  out  1  sticky: a push was dropped

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all FIFO counts, read and write pointers = 0
  - round-robin pointer = 0; grant lock cleared
  - overflow_err = 0, wb_valid = 0, wb_rd/wb_id/wb_pc/wb_unit = 0
  - unit_ready = all ones
  - Reset mid-operation discards all buffered entries; no writeback is emitted for them.
- Push: unit_done[i]=1 at posedge writes {rd,id,pc} into FIFO i. No bypass: earliest wb_valid is the next cycle (latency 1).
- unit_ready[i] = (count[i] < FIFO_DEPTH). Combinational from registered count; it does not depend on the same-cycle pop.
- Full FIFO:
  - push with a same-cycle pop is accepted (count unchanged).
  - push without a pop is dropped; overflow_err sets and stays set until rst.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Count is held in clog2(FIFO_DEPTH)+1 bits.
- wb_valid = OR of non-empty FIFOs. wb_rd/wb_id/wb_pc/wb_unit come from the head of the granted FIFO.
- Arbitration:
  - Round robin starting at rr_ptr; grant goes to the first non-empty FIFO at index ≥ rr_ptr, wrapping.
  - On handshake (wb_valid && wb_ready), pop the granted FIFO and set rr_ptr = grant+1 mod NUM_UNITS.
- Stall: while wb_valid && !wb_ready, the grant is locked. Outputs stay stable and other FIFOs cannot preempt; pushes continue.
- Same-id entries from one unit leave in push order. There is no ordering guarantee across units.
- Empty: wb_valid=0; wb_ready is ignored; rr_ptr is unchanged.

Optional Feature:
- DEXIE_WB_PC_TRACE_EN defined:
  - PC is stored in every FIFO entry and driven on wb_pc.
- Undefined:
  - PC storage is removed, wb_pc is tied 0, and unit_pc is ignored.
  - FIFO entry width drops by 32 bits.
  - All other timing is identical.

Decomposition:
- Shared package: wb_entry_t (rd XLEN, id ID_W, pc 32 under the macro) and the WB_UNIT_ALU = 0 constant.
- One sub-module, wb_unit_fifo: a single-unit circular buffer with push, pop, full, empty and count, instantiated NUM_UNITS times.
- The arbiter stays inline.

Test Plan:
- Single ALU pulse: unit_done=0001, rd=0x0000_0005, id=2, pc=0x100, wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_id=2, wb_pc=0x100, wb_unit=0; the cycle after, wb_valid=0.
- Four units pulse in the same cycle with rd=0x10/0x20/0x30/0x40, wb_ready=1 -> 4 consecutive writebacks in unit order 0,1,2,3; rr_ptr ends at 0.
- wb_ready=0 for 5 cycles with units 0 and 2 loaded -> wb_unit=0, wb_rd constant all 5 cycles; after release, unit 0 then unit 2.
- FIFO_DEPTH=2, wb_ready=0, three ALU pulses -> unit_ready[0] falls after the 2nd push; the 3rd is dropped; overflow_err=1 and holds; only 2 writebacks after release.
- Full FIFO 0 with push and pop in the same cycle -> count stays 2, no overflow, 3 entries drain in FIFO order.
- rst asserted with 3 entries buffered -> next cycle wb_valid=0, unit_ready=1111, overflow_err=0; no stale entry appears afterwards.

Source files
------------

// File: rtl/unit_wb_collector_pkg.sv
// Shared types and constants for the unit writeback collector.
// Entry layout carries the PC only when DEXIE_WB_PC_TRACE_EN is defined.
package unit_wb_collector_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned WB_ID_W     = 3;
  localparam int unsigned WB_UNIT_ALU = 0;

  // Default-configuration entry layout; the top builds its own for a non-default ID_W.
  typedef struct packed {
    logic [XLEN-1:0]    rd;
    logic [WB_ID_W-1:0] id;
`ifdef DEXIE_WB_PC_TRACE_EN
    logic [31:0]        pc;
`endif
  } wb_entry_t;

endpackage

// File: rtl/unit_wb_collector_if.sv
// Unit-side done/result bundle plus the single writeback port of the collector.
// master drives units and wb_ready; slave is the collector.
interface unit_wb_collector_if
  import unit_wb_collector_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned ID_W      = 3
) ();

  localparam int unsigned UnitW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]           unit_done;
  logic [NUM_UNITS-1:0][XLEN-1:0] unit_rd;
  logic [NUM_UNITS-1:0][ID_W-1:0] unit_id;
  logic [NUM_UNITS-1:0][31:0]     unit_pc;
  logic [NUM_UNITS-1:0]           unit_ready;
  logic                           wb_valid;
  logic                           wb_ready;
  logic [XLEN-1:0]                wb_rd;
  logic [ID_W-1:0]                wb_id;
  logic [31:0]                    wb_pc;
  logic [UnitW-1:0]               wb_unit;
  logic                           overflow_err;

  modport master (
    output unit_done, unit_rd, unit_id, unit_pc, wb_ready,
    input  unit_ready, wb_valid, wb_rd, wb_id, wb_pc, wb_unit, overflow_err
  );

  modport slave (
    input  unit_done, unit_rd, unit_id, unit_pc, wb_ready,
    output unit_ready, wb_valid, wb_rd, wb_id, wb_pc, wb_unit, overflow_err
  );

endinterface

// File: rtl/unit_wb_collector_wb_unit_fifo.sv
// Single-unit circular buffer (power-of-two depth) with push, pop, full, empty and count.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module wb_unit_fifo
  import unit_wb_collector_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  entry_t                     data_i,
  output entry_t                     data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  entry_t          mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/unit_wb_collector.sv
// Collects per-unit writeback pulses into small FIFOs and round-robin arbitrates them onto one
// valid/ready writeback port. Optional PC trace storage: DEXIE_WB_PC_TRACE_EN.
module unit_wb_collector
  import unit_wb_collector_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ID_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  unit_wb_collector_if.slave bus
);

  localparam int unsigned UnitW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic [ID_W-1:0] id;
`ifdef DEXIE_WB_PC_TRACE_EN
    logic [31:0]     pc;
`endif
  } entry_t;

  entry_t               head [NUM_UNITS];
  logic [NUM_UNITS-1:0] full, empty, drop, pop;
  logic [CntW-1:0]      unused_count [NUM_UNITS];

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    entry_t din;
    assign din.rd = bus.unit_rd[u];
    assign din.id = bus.unit_id[u];
`ifdef DEXIE_WB_PC_TRACE_EN
    assign din.pc = bus.unit_pc[u];
`endif

    wb_unit_fifo #(
      .Depth   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (bus.unit_done[u]),
      .pop_i   (pop[u]),
      .data_i  (din),
      .data_o  (head[u]),
      .full_o  (full[u]),
      .empty_o (empty[u]),
      .drop_o  (drop[u]),
      .count_o (unused_count[u])
    );
  end

`ifndef DEXIE_WB_PC_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^bus.unit_pc;
`endif

  logic [UnitW-1:0] rr_ptr_q, rr_grant, grant, lock_grant_q, next_ptr;
  logic             lock_q, any_valid, handshake, found, overflow_q;
  int unsigned      idx;
  entry_t           sel;

  assign any_valid = ~&empty;
  assign handshake = any_valid && bus.wb_ready;
  // A stalled grant is held so a newly filled FIFO earlier in the rotation cannot preempt it.
  assign grant     = lock_q ? lock_grant_q : rr_grant;
  assign next_ptr  = (grant == UnitW'(NUM_UNITS - 1)) ? '0 : grant + UnitW'(1);
  assign sel       = head[grant];

  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_UNITS;
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        rr_grant = UnitW'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (handshake) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (handshake) rr_ptr_q <= next_ptr;
      lock_q       <= any_valid && !bus.wb_ready;
      lock_grant_q <= grant;
      overflow_q   <= overflow_q | (|drop);
    end
  end

  assign bus.unit_ready   = ~full;
  assign bus.wb_valid     = any_valid;
  assign bus.wb_rd        = any_valid ? sel.rd : '0;
  assign bus.wb_id        = any_valid ? sel.id : '0;
  assign bus.wb_unit      = any_valid ? grant : '0;
  assign bus.overflow_err = overflow_q;
`ifdef DEXIE_WB_PC_TRACE_EN
  assign bus.wb_pc        = any_valid ? sel.pc : '0;
`else
  assign bus.wb_pc        = '0;
`endif

endmodule

// File: tb/tb_unit_wb_collector.sv
// Directed self-checking bench for unit_wb_collector (4 units, depth 2).
module tb_unit_wb_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  unit_wb_collector_if #(.NUM_UNITS(4), .ID_W(3)) bus ();

  unit_wb_collector #(
    .NUM_UNITS  (4),
    .FIFO_DEPTH (2),
    .ID_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DEXIE_WB_PC_TRACE_EN
  localparam bit PcOn = 1'b1;
`else
  localparam bit PcOn = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [31:0] rd, input logic [2:0] id,
                          input logic [31:0] pc);
    bus.unit_done[u] = 1'b1;
    bus.unit_rd[u]   = rd;
    bus.unit_id[u]   = id;
    bus.unit_pc[u]   = pc;
  endtask

  task automatic do_reset();
    bus.unit_done = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.unit_done = '0;
    bus.unit_rd   = '0;
    bus.unit_id   = '0;
    bus.unit_pc   = '0;
    bus.wb_ready  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%0h exp=0", bus.wb_valid); end
    checks++; if (bus.unit_ready !== 4'b1111) begin failures++;
      $display("FAIL reset_ready got=%0h exp=f", bus.unit_ready); end
    checks++; if (bus.overflow_err !== 1'b0) begin failures++;
      $display("FAIL reset_overflow got=%0h exp=0", bus.overflow_err); end
    checks++; if (bus.wb_rd !== 32'h0) begin failures++;
      $display("FAIL reset_rd got=%0h exp=0", bus.wb_rd); end
    checks++; if (bus.wb_unit !== 2'd0) begin failures++;
      $display("FAIL reset_unit got=%0h exp=0", bus.wb_unit); end
  endtask

  task automatic test_single();
    logic [31:0] pc_exp;
    pc_exp = PcOn ? 32'h100 : 32'h0;
    bus.wb_ready = 1'b1;
    set_unit(0, 32'h5, 3'd2, 32'h100);
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL single_no_bypass got=%0h exp=0", bus.wb_valid); end
    tick();
    bus.unit_done = '0;
    checks++; if (bus.wb_valid !== 1'b1) begin failures++;
      $display("FAIL single_valid got=%0h exp=1", bus.wb_valid); end
    checks++; if (bus.wb_rd !== 32'h5) begin failures++;
      $display("FAIL single_rd got=%0h exp=5", bus.wb_rd); end
    checks++; if (bus.wb_id !== 3'd2) begin failures++;
      $display("FAIL single_id got=%0h exp=2", bus.wb_id); end
    checks++; if (bus.wb_pc !== pc_exp) begin failures++;
      $display("FAIL single_pc got=%0h exp=%0h", bus.wb_pc, pc_exp); end
    checks++; if (bus.wb_unit !== 2'd0) begin failures++;
      $display("FAIL single_unit got=%0h exp=0", bus.wb_unit); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL single_drained got=%0h exp=0", bus.wb_valid); end
  endtask

  task automatic test_all_units();
    do_reset();
    bus.wb_ready = 1'b1;
    for (int u = 0; u < 4; u++) set_unit(u, 32'h10 * (u + 1), 3'(u + 4), 32'h200 + u);
    tick();
    bus.unit_done = '0;
    for (int u = 0; u < 4; u++) begin
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_unit !== 2'(u)) begin failures++;
        $display("FAIL all_order[%0d] got=%0h/%0h exp=1/%0h", u, bus.wb_valid, bus.wb_unit, u); end
      checks++; if (bus.wb_rd !== 32'h10 * (u + 1) || bus.wb_id !== 3'(u + 4)) begin failures++;
        $display("FAIL all_data[%0d] got=%0h/%0h exp=%0h/%0h", u, bus.wb_rd, bus.wb_id,
                 32'h10 * (u + 1), u + 4); end
      tick();
    end
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL all_drained got=%0h exp=0", bus.wb_valid); end
    // Pointer should be back at 0: unit 0 beats unit 3.
    set_unit(0, 32'h70, 3'd0, 32'h0);
    set_unit(3, 32'h73, 3'd3, 32'h0);
    tick();
    bus.unit_done = '0;
    checks++; if (bus.wb_unit !== 2'd0 || bus.wb_rd !== 32'h70) begin failures++;
      $display("FAIL rr_wrap_first got=%0h/%0h exp=0/70", bus.wb_unit, bus.wb_rd); end
    tick();
    checks++; if (bus.wb_unit !== 2'd3 || bus.wb_rd !== 32'h73) begin failures++;
      $display("FAIL rr_wrap_second got=%0h/%0h exp=3/73", bus.wb_unit, bus.wb_rd); end
    tick();
  endtask

  task automatic test_stall();
    bus.wb_ready = 1'b0;
    set_unit(0, 32'hA0, 3'd1, 32'h0);
    set_unit(2, 32'hC0, 3'd3, 32'h0);
    tick();
    bus.unit_done = '0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_unit !== 2'd0 || bus.wb_rd !== 32'hA0)
        begin failures++;
        $display("FAIL stall_hold[%0d] got=%0h/%0h/%0h exp=1/0/a0", c, bus.wb_valid,
                 bus.wb_unit, bus.wb_rd); end
      tick();
    end
    bus.wb_ready = 1'b1;
    checks++; if (bus.wb_unit !== 2'd0 || bus.wb_rd !== 32'hA0) begin failures++;
      $display("FAIL stall_rel0 got=%0h/%0h exp=0/a0", bus.wb_unit, bus.wb_rd); end
    tick();
    checks++; if (bus.wb_unit !== 2'd2 || bus.wb_rd !== 32'hC0) begin failures++;
      $display("FAIL stall_rel2 got=%0h/%0h exp=2/c0", bus.wb_unit, bus.wb_rd); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL stall_drained got=%0h exp=0", bus.wb_valid); end
  endtask

  task automatic test_grant_lock();
    // Pointer sits at 3 here; unit 3 arriving during a stall on unit 1 must not preempt it.
    bus.wb_ready = 1'b0;
    set_unit(1, 32'h11, 3'd1, 32'h0);
    tick();
    bus.unit_done = '0;
    set_unit(3, 32'h33, 3'd3, 32'h0);
    tick();
    bus.unit_done = '0;
    tick();
    checks++; if (bus.wb_unit !== 2'd1 || bus.wb_rd !== 32'h11) begin failures++;
      $display("FAIL lock_hold got=%0h/%0h exp=1/11", bus.wb_unit, bus.wb_rd); end
    bus.wb_ready = 1'b1;
    tick();
    checks++; if (bus.wb_unit !== 2'd3 || bus.wb_rd !== 32'h33) begin failures++;
      $display("FAIL lock_next got=%0h/%0h exp=3/33", bus.wb_unit, bus.wb_rd); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    bus.wb_ready = 1'b0;
    set_unit(0, 32'h1, 3'd0, 32'h0);
    tick();
    checks++; if (bus.unit_ready[0] !== 1'b1) begin failures++;
      $display("FAIL ovf_ready1 got=%0h exp=1", bus.unit_ready[0]); end
    set_unit(0, 32'h2, 3'd0, 32'h0);
    tick();
    checks++; if (bus.unit_ready !== 4'b1110 || bus.overflow_err !== 1'b0) begin failures++;
      $display("FAIL ovf_full got=%0h/%0h exp=e/0", bus.unit_ready, bus.overflow_err); end
    set_unit(0, 32'h3, 3'd0, 32'h0);
    tick();
    bus.unit_done = '0;
    checks++; if (bus.overflow_err !== 1'b1) begin failures++;
      $display("FAIL ovf_set got=%0h exp=1", bus.overflow_err); end
    tick();
    bus.wb_ready = 1'b1;
    checks++; if (bus.wb_rd !== 32'h1) begin failures++;
      $display("FAIL ovf_drain0 got=%0h exp=1", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_rd !== 32'h2) begin failures++;
      $display("FAIL ovf_drain1 got=%0h exp=2", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.overflow_err !== 1'b1) begin failures++;
      $display("FAIL ovf_end got=%0h/%0h exp=0/1", bus.wb_valid, bus.overflow_err); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    bus.wb_ready = 1'b0;
    set_unit(0, 32'h31, 3'd0, 32'h0);
    tick();
    set_unit(0, 32'h32, 3'd0, 32'h0);
    tick();
    set_unit(0, 32'h33, 3'd0, 32'h0);
    bus.wb_ready = 1'b1;
    checks++; if (bus.wb_rd !== 32'h31 || bus.unit_ready[0] !== 1'b0) begin failures++;
      $display("FAIL pp_head got=%0h/%0h exp=31/0", bus.wb_rd, bus.unit_ready[0]); end
    tick();
    bus.unit_done = '0;
    checks++; if (bus.unit_ready[0] !== 1'b0 || bus.overflow_err !== 1'b0) begin failures++;
      $display("FAIL pp_count got=%0h/%0h exp=0/0", bus.unit_ready[0], bus.overflow_err); end
    checks++; if (bus.wb_rd !== 32'h32) begin failures++;
      $display("FAIL pp_second got=%0h exp=32", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_rd !== 32'h33 || bus.unit_ready[0] !== 1'b1) begin failures++;
      $display("FAIL pp_third got=%0h/%0h exp=33/1", bus.wb_rd, bus.unit_ready[0]); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++;
      $display("FAIL pp_drained got=%0h exp=0", bus.wb_valid); end
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b0;
    set_unit(0, 32'h51, 3'd0, 32'h0);
    set_unit(1, 32'h61, 3'd1, 32'h0);
    tick();
    bus.unit_done = '0;
    set_unit(0, 32'h52, 3'd0, 32'h0);
    tick();
    set_unit(0, 32'h53, 3'd0, 32'h0);
    tick();
    bus.unit_done = '0;
    checks++; if (bus.overflow_err !== 1'b1 || bus.wb_valid !== 1'b1) begin failures++;
      $display("FAIL mid_pre got=%0h/%0h exp=1/1", bus.overflow_err, bus.wb_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0 || bus.unit_ready !== 4'b1111) begin failures++;
      $display("FAIL mid_rst got=%0h/%0h exp=0/f", bus.wb_valid, bus.unit_ready); end
    checks++; if (bus.overflow_err !== 1'b0 || bus.wb_rd !== 32'h0) begin failures++;
      $display("FAIL mid_rst_err got=%0h/%0h exp=0/0", bus.overflow_err, bus.wb_rd); end
    bus.wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b0) begin failures++;
        $display("FAIL mid_stale[%0d] got=%0h exp=0", c, bus.wb_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_units();
    test_stall();
    test_grant_lock();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
